// File: rtl/mintz80_mmu_ctl_if.sv
// MinTZ80 MMU write-port bus: CPU memmap write request/response plus the
// page-register write port. master = requester/observer, slave = sequencer.
interface mintz80_mmu_ctl_if;
   logic       cpu_wr_req;
   logic [2:0] cpu_adr;
   logic [2:0] cpu_data;
   logic       cpu_ack;
   logic       cpu_nak;
   logic       mm_we;
   logic [2:0] mm_adr;
   logic [2:0] mm_data;

   modport master (
      output cpu_wr_req, cpu_adr, cpu_data,
      input  cpu_ack, cpu_nak, mm_we, mm_adr, mm_data
   );

   modport slave (
      input  cpu_wr_req, cpu_adr, cpu_data,
      output cpu_ack, cpu_nak, mm_we, mm_adr, mm_data
   );
endinterface

// File: rtl/mintz80_mmu_ctl.sv
// MinTZ80 MMU page-register write-port sequencer: init/restore, CPU writes,
// lock. Ports: clk, reset (sync, active-low), bus (slave: cpu req/ack/nak and
// mm write port), restore_req, lock_req, unlock_req, busy, init_done, locked.
// Optional lock logic: define MMU_CTL_LOCK_EN.
module mintz80_mmu_ctl #(
   parameter logic [23:0] DEFAULT_MAP = 24'o11111110
) (
   input  logic                  clk,
   input  logic                  reset,
   mintz80_mmu_ctl_if.slave      bus,
   input  logic                  restore_req,
   input  logic                  lock_req,
   input  logic                  unlock_req,
   output logic                  busy,
   output logic                  init_done,
   output logic                  locked
);

`ifdef MMU_CTL_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   typedef enum logic {INIT, RUN} state_t;

   state_t     state;
   logic [2:0] cnt;
   logic       pend_v;
   logic [2:0] pend_adr;
   logic [2:0] pend_data;
   logic [2:0] idx;
   logic [4:0] base;
   logic [2:0] slot_val;
   logic       lock_nxt;

   // A restore restarts the sequence this very edge at slot 0.
   assign idx      = restore_req ? 3'd0 : cnt;
   assign base     = 5'(idx) * 5'd3;
   assign slot_val = DEFAULT_MAP[base +: 3];
   // Lock wins over unlock when both strobe together.
   assign lock_nxt = LOCK_EN & (lock_req | (locked & ~unlock_req));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= INIT;
         cnt         <= 3'd0;
         pend_v      <= 1'b0;
         pend_adr    <= 3'd0;
         pend_data   <= 3'd0;
         bus.mm_we   <= 1'b0;
         bus.mm_adr  <= 3'd0;
         bus.mm_data <= 3'd0;
         bus.cpu_ack <= 1'b0;
         bus.cpu_nak <= 1'b0;
         busy        <= 1'b1;
         init_done   <= 1'b0;
         locked      <= 1'b0;
      end else begin
         bus.mm_we   <= 1'b0;
         bus.cpu_ack <= 1'b0;
         bus.cpu_nak <= 1'b0;
         locked      <= lock_nxt;
         if (state == RUN) init_done <= 1'b1;
         if (state == INIT || restore_req) begin
            bus.mm_we   <= 1'b1;
            bus.mm_adr  <= idx;
            bus.mm_data <= slot_val;
            busy        <= 1'b1;
            cnt         <= 3'(idx + 3'd1);
            state       <= (idx == 3'd7) ? RUN : INIT;
            if (bus.cpu_wr_req) begin
               if (pend_v) begin
                  bus.cpu_nak <= 1'b1;
               end else begin
                  pend_v    <= 1'b1;
                  pend_adr  <= bus.cpu_adr;
                  pend_data <= bus.cpu_data;
               end
            end
         end else begin
            busy <= 1'b0;
            if (pend_v) begin
               // Buffered write owns the port; a new request refills it.
               if (locked) begin
                  bus.cpu_nak <= 1'b1;
               end else begin
                  bus.mm_we   <= 1'b1;
                  bus.mm_adr  <= pend_adr;
                  bus.mm_data <= pend_data;
                  bus.cpu_ack <= 1'b1;
               end
               pend_v <= bus.cpu_wr_req;
               if (bus.cpu_wr_req) begin
                  pend_adr  <= bus.cpu_adr;
                  pend_data <= bus.cpu_data;
               end
            end else if (bus.cpu_wr_req) begin
               if (locked) begin
                  bus.cpu_nak <= 1'b1;
               end else begin
                  bus.mm_we   <= 1'b1;
                  bus.mm_adr  <= bus.cpu_adr;
                  bus.mm_data <= bus.cpu_data;
                  bus.cpu_ack <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mintz80_mmu_ctl.sv
// Scoreboard bench for mintz80_mmu_ctl: directed plan plus random traffic
// against a queue-based reference model.
module tb_mintz80_mmu_ctl;

`ifdef MMU_CTL_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic clk = 1'b1;
   always #5 clk = ~clk;

   logic reset;
   logic restore_req;
   logic lock_req;
   logic unlock_req;
   logic busy;
   logic init_done;
   logic locked;

   mintz80_mmu_ctl_if bus ();

   mintz80_mmu_ctl dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .restore_req (restore_req),
      .lock_req    (lock_req),
      .unlock_req  (unlock_req),
      .busy        (busy),
      .init_done   (init_done),
      .locked      (locked)
   );

   typedef struct {
      bit       we;
      bit [2:0] adr;
      bit [2:0] data;
      bit       ack;
      bit       nak;
      bit       bsy;
      bit       done;
      bit       lk;
   } exp_t;

   exp_t     sb[$];
   bit [5:0] pq[$];
   int       m_slot;
   bit       m_lock;
   bit       m_done;
   int       n_cmp = 0;
   int       n_bad = 0;
   int       cyc = 0;
   bit       fin = 1'b0;

   // Slots still to initialise: m_slot < 8. Pending CPU writes live in pq.
   task automatic model(input bit rstn, input bit req, input bit [2:0] a,
                        input bit [2:0] d, input bit rs, input bit lk,
                        input bit ul, output exp_t e);
      int s;
      bit [5:0] p;
      e = '{default: 0};
      if (!rstn) begin
         m_slot = 0;
         pq.delete();
         m_lock = 0;
         m_done = 0;
         e.bsy = 1;
         return;
      end
      if (rs || m_slot < 8) begin
         if (m_slot == 8) m_done = 1;
         s = rs ? 0 : m_slot;
         e.we = 1;
         e.adr = 3'(s);
         e.data = (s == 0) ? 3'd0 : 3'd1;
         e.bsy = 1;
         m_slot = s + 1;
         if (req) begin
            if (pq.size() != 0) e.nak = 1;
            else pq.push_back({a, d});
         end
      end else begin
         m_done = 1;
         if (pq.size() != 0 || req) begin
            if (pq.size() != 0) begin
               p = pq.pop_front();
               if (req) pq.push_back({a, d});
            end else begin
               p = {a, d};
            end
            if (m_lock) begin
               e.nak = 1;
            end else begin
               e.we = 1;
               e.ack = 1;
               e.adr = p[5:3];
               e.data = p[2:0];
            end
         end
      end
      if (LOCK_EN) begin
         if (lk) m_lock = 1;
         else if (ul) m_lock = 0;
      end
      e.done = m_done;
      e.lk = m_lock;
   endtask

   task automatic step(input bit rstn, input bit req, input bit [2:0] a,
                       input bit [2:0] d, input bit rs, input bit lk,
                       input bit ul);
      exp_t e;
      @(negedge clk);
      reset = rstn;
      bus.cpu_wr_req = req;
      bus.cpu_adr = a;
      bus.cpu_data = d;
      restore_req = rs;
      lock_req = lk;
      unlock_req = ul;
      model(rstn, req, a, d, rs, lk, ul, e);
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input bit [2:0] a, input bit [2:0] d);
      step(1, 1, a, d, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      bit ok;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sb.size() == 0) begin
            if (!fin) begin
               n_cmp++;
               n_bad++;
               $display("FAIL underflow cyc%0d: got no expected entry, required one", cyc);
            end
         end else begin
            e = sb.pop_front();
            ok = (bus.mm_we == e.we) && (bus.cpu_ack == e.ack) &&
                 (bus.cpu_nak == e.nak) && (busy == e.bsy) &&
                 (init_done == e.done) && (locked == e.lk) &&
                 (!e.we || (bus.mm_adr == e.adr && bus.mm_data == e.data));
            n_cmp++;
            if (!ok) begin
               n_bad++;
               $display("FAIL outputs cyc%0d: got we=%0d adr=%0d data=%0d ack=%0d nak=%0d busy=%0d done=%0d lk=%0d, required we=%0d adr=%0d data=%0d ack=%0d nak=%0d busy=%0d done=%0d lk=%0d",
                        cyc, bus.mm_we, bus.mm_adr, bus.mm_data, bus.cpu_ack,
                        bus.cpu_nak, busy, init_done, locked, e.we, e.adr,
                        e.data, e.ack, e.nak, e.bsy, e.done, e.lk);
            end
         end
      end
   end

   initial begin : driver
      reset = 0;
      bus.cpu_wr_req = 0;
      bus.cpu_adr = 0;
      bus.cpu_data = 0;
      restore_req = 0;
      lock_req = 0;
      unlock_req = 0;
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      idle(12);
      wr(5, 6);
      idle(2);
      wr(1, 2);
      wr(2, 3);
      wr(3, 4);
      idle(2);
      step(0, 0, 0, 0, 0, 0, 0);
      idle(2);
      wr(2, 4);
      wr(3, 5);
      idle(10);
      step(1, 0, 0, 0, 0, 1, 0);
      wr(1, 3);
      step(1, 0, 0, 0, 0, 0, 1);
      wr(1, 3);
      step(1, 0, 0, 0, 0, 1, 1);
      idle(1);
      step(1, 1, 4, 4, 1, 0, 0);
      idle(10);
      step(1, 0, 0, 0, 0, 0, 1);
      step(1, 1, 0, 7, 1, 0, 0);
      idle(10);
      step(0, 0, 0, 0, 0, 0, 0);
      idle(4);
      step(0, 0, 0, 0, 0, 0, 0);
      idle(10);
      step(1, 0, 0, 0, 0, 1, 0);
      idle(2);
      step(1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) != 0,
              $urandom_range(99) < 45,
              3'($urandom_range(7)), 3'($urandom_range(7)),
              $urandom_range(99) < 3,
              $urandom_range(99) < 5,
              $urandom_range(99) < 6);
      end
      idle(12);
      fin = 1;
      @(posedge clk);
      #2;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d entries left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
